// File: rtl/sfx_audio_mixer.sv
// Duck-mixes internally generated "hit" and "block" tones over the PWM-scaled BGM square wave.
// Optional macro SFX_SWEEP_EN: hit tone half-period grows by one cycle per phase toggle (falling pitch).
module sfx_audio_mixer #(
    parameter int HIT_HALF_PER   = 113636,
    parameter int BLOCK_HALF_PER = 75757,
    parameter int SFX_LEN        = 10000000,
    parameter int GAP_LEN        = 1000000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bgm_in,
    input  logic       hit_trig,
    input  logic       block_trig,
    input  logic [2:0] volume,
    input  logic       mute,
    output logic       speaker,
    output logic       sfx_busy,
    output logic [1:0] sfx_id
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [1:0] ID_NONE  = 2'b00;
    localparam logic [1:0] ID_HIT   = 2'b01;
    localparam logic [1:0] ID_BLOCK = 2'b10;

    localparam logic [CNT_W-1:0] HIT_HP   = CNT_W'(HIT_HALF_PER);
    localparam logic [CNT_W-1:0] BLOCK_HP = CNT_W'(BLOCK_HALF_PER);
    localparam logic [CNT_W-1:0] SFX_LOAD = CNT_W'(SFX_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             bgm_s1;
    logic             bgm_s2;
    logic [2:0]       pwm_cnt;
    logic [1:0]       state;
    logic [CNT_W-1:0] dur_cnt;
    logic [CNT_W-1:0] tone_cnt;
    logic [CNT_W-1:0] half_per;
    logic             phase;
    logic             bgm_gate;
    logic             start;
    logic [1:0]       start_id;
    logic             tone_wrap;
    logic             speaker_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bgm_s1  <= 1'b0;
            bgm_s2  <= 1'b0;
            pwm_cnt <= 3'd0;
        end else begin
            bgm_s1  <= bgm_in;
            bgm_s2  <= bgm_s1;
            pwm_cnt <= pwm_cnt + 3'd1;
        end
    end

    assign bgm_gate = (volume == 3'd7) || (pwm_cnt < volume);

    // Hit always (re)starts; a block is dropped only while a hit is still playing.
    assign start    = hit_trig || (block_trig && !(state == PLAY && sfx_id == ID_HIT));
    assign start_id = hit_trig ? ID_HIT : ID_BLOCK;

`ifdef SFX_SWEEP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half_per <= '0;
        end else if (start) begin
            half_per <= hit_trig ? HIT_HP : BLOCK_HP;
        end else if (state == PLAY && tone_wrap && sfx_id == ID_HIT) begin
            half_per <= half_per + ONE;
        end
    end
`else
    assign half_per = (sfx_id == ID_HIT) ? HIT_HP : BLOCK_HP;
`endif

    assign tone_wrap = (tone_cnt == half_per - ONE);

    always_comb begin
        speaker_next = 1'b0;
        if (!mute) begin
            case (state)
                IDLE:    speaker_next = bgm_s2 & bgm_gate;
                PLAY:    speaker_next = phase;
                default: speaker_next = 1'b0;
            endcase
        end
    end

    // Outputs are registered alongside the state so busy/id change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            phase    <= 1'b0;
            sfx_id   <= ID_NONE;
            sfx_busy <= 1'b0;
            speaker  <= 1'b0;
        end else begin
            speaker <= speaker_next;
            if (start) begin
                state    <= PLAY;
                dur_cnt  <= SFX_LOAD;
                tone_cnt <= '0;
                phase    <= 1'b1;
                sfx_id   <= start_id;
                sfx_busy <= 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        if (tone_wrap) begin
                            tone_cnt <= '0;
                            phase    <= ~phase;
                        end else begin
                            tone_cnt <= tone_cnt + ONE;
                        end
                        if (dur_cnt == '0) begin
                            state   <= GAP;
                            dur_cnt <= GAP_LOAD;
                            sfx_id  <= ID_NONE;
                        end else begin
                            dur_cnt <= dur_cnt - ONE;
                        end
                    end
                    GAP: begin
                        if (dur_cnt == '0) begin
                            state    <= IDLE;
                            sfx_busy <= 1'b0;
                        end else begin
                            dur_cnt <= dur_cnt - ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sfx_audio_mixer.sv
// Self-checking bench for sfx_audio_mixer: PWM vector table, scripted SFX sequences,
// and randomized stimulus compared every cycle against a timeline-based reference model.
module tb_sfx_audio_mixer;
    localparam int HIT_HP   = 4;
    localparam int BLOCK_HP = 3;
    localparam int SFX_LEN  = 40;
    localparam int GAP_LEN  = 10;
    localparam int CNT_W    = 8;
    localparam int IDLE_T   = SFX_LEN + GAP_LEN;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bgm_in = 1'b0;
    logic       hit_trig = 1'b0;
    logic       block_trig = 1'b0;
    logic [2:0] volume = 3'd7;
    logic       mute = 1'b0;
    logic       speaker;
    logic       sfx_busy;
    logic [1:0] sfx_id;

    int checks = 0;
    int failures = 0;

    // Reference model: time elapsed since the current SFX started (IDLE_T means idle).
    int         since = IDLE_T;
    int         cur_id = 0;
    int         edges = 0;
    logic       bgm_d1 = 1'b0;
    logic       bgm_d2 = 1'b0;
    logic       exp_spk;
    logic       exp_busy;
    logic [1:0] exp_id;

    typedef struct {
        logic [2:0] vol;
        logic       mute;
        logic       bgm;
        int         exp_high;
    } vec_t;
    vec_t vecs[8];
    int   high;
    logic rb, rh, rblk, rmute;
    logic [2:0] rvol;

    sfx_audio_mixer #(
        .HIT_HALF_PER  (HIT_HP),
        .BLOCK_HALF_PER(BLOCK_HP),
        .SFX_LEN       (SFX_LEN),
        .GAP_LEN       (GAP_LEN),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bgm_in    (bgm_in),
        .hit_trig  (hit_trig),
        .block_trig(block_trig),
        .volume    (volume),
        .mute      (mute),
        .speaker   (speaker),
        .sfx_busy  (sfx_busy),
        .sfx_id    (sfx_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic b, input logic bg,
                                 input logic [2:0] vol, input logic m);
        @(negedge clk);
        hit_trig   = h;
        block_trig = b;
        bgm_in     = bg;
        volume     = vol;
        mute       = m;
    endtask

    // Tone level at t cycles into a PLAY: starts high, flips after each half-period.
    function automatic logic tone_phase(input int t, input int idv);
        int   h = (idv == 1) ? HIT_HP : BLOCK_HP;
        int   edge_t = h;
        logic ph = 1'b1;
        while (t >= edge_t) begin
            ph = ~ph;
`ifdef SFX_SWEEP_EN
            if (idv == 1) h++;
`endif
            edge_t += h;
        end
        return ph;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            since  = IDLE_T;
            cur_id = 0;
            edges  = 0;
            bgm_d1 = 1'b0;
            bgm_d2 = 1'b0;
        end else begin
            if (mute)
                exp_spk = 1'b0;
            else if (since < SFX_LEN)
                exp_spk = tone_phase(since, cur_id);
            else if (since < IDLE_T)
                exp_spk = 1'b0;
            else
                exp_spk = bgm_d2 & ((volume == 3'd7) || ((edges % 8) < int'(volume)));
            edges++;
            bgm_d2 = bgm_d1;
            bgm_d1 = bgm_in;
            if (hit_trig || (block_trig && !(since < SFX_LEN && cur_id == 1))) begin
                since  = 0;
                cur_id = hit_trig ? 1 : 2;
            end else if (since < IDLE_T) begin
                since++;
            end
            exp_busy = (since < IDLE_T);
            exp_id   = (since < SFX_LEN) ? 2'(cur_id) : 2'd0;
            #1;
            checkOutput("model_speaker", speaker, exp_spk);
            checkOutput("model_busy", sfx_busy, exp_busy);
            checkOutput("model_id", sfx_id, exp_id);
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd3, 1'b0, 1'b1, 3};
        vecs[1] = '{3'd0, 1'b0, 1'b1, 0};
        vecs[2] = '{3'd7, 1'b0, 1'b1, 8};
        vecs[3] = '{3'd5, 1'b0, 1'b1, 5};
        vecs[4] = '{3'd1, 1'b0, 1'b1, 1};
        vecs[5] = '{3'd6, 1'b0, 1'b1, 6};
        vecs[6] = '{3'd7, 1'b1, 1'b1, 0};
        vecs[7] = '{3'd7, 1'b0, 1'b0, 0};

        $display("[TB] start");
        @(posedge clk);
        #1;
        checkOutput("reset_speaker", speaker, 0);
        checkOutput("reset_busy", sfx_busy, 0);
        checkOutput("reset_id", sfx_id, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // BGM pass-through latency.
        repeat (4) applyStimulus(0, 0, 0, 3'd7, 0);
        applyStimulus(0, 0, 1, 3'd7, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bgm_latency_%0d", k), speaker, (k == 3) ? 1 : 0);
        end
        for (int c = 0; c < 200; c++)
            applyStimulus(0, 0, ((c / 50) % 2) == 0, 3'd7, 0);

        // PWM volume table with no SFX active.
        for (int i = 0; i < 8; i++) begin
            repeat (4) applyStimulus(0, 0, vecs[i].bgm, vecs[i].vol, vecs[i].mute);
            high = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                high += int'(speaker);
            end
            checkOutput($sformatf("pwm_vec%0d", i), high, vecs[i].exp_high);
        end

        // Hit SFX full cycle.
        applyStimulus(1, 0, 1, 3'd7, 0);
        @(posedge clk);
        #1;
        checkOutput("hit_start_id", sfx_id, 1);
        checkOutput("hit_start_busy", sfx_busy, 1);
        applyStimulus(0, 0, 1, 3'd7, 0);
        for (int k = 1; k <= 51; k++) begin
            @(posedge clk);
            #1;
            if (k == 4)  checkOutput("hit_tone_high", speaker, 1);
            if (k == 5)  checkOutput("hit_tone_low", speaker, 0);
            if (k == 39) checkOutput("hit_last_play_id", sfx_id, 1);
            if (k == 40) checkOutput("hit_gap_id", sfx_id, 0);
            if (k == 40) checkOutput("hit_gap_busy", sfx_busy, 1);
            if (k == 45) checkOutput("hit_gap_speaker", speaker, 0);
            if (k == 49) checkOutput("hit_gap_end_busy", sfx_busy, 1);
            if (k == 50) checkOutput("hit_idle_busy", sfx_busy, 0);
            if (k == 51) checkOutput("hit_bgm_resume", speaker, 1);
        end

        // Simultaneous triggers, then a block during the hit.
        applyStimulus(1, 1, 1, 3'd7, 0);
        @(posedge clk);
        #1;
        checkOutput("simul_id", sfx_id, 1);
        repeat (4) applyStimulus(0, 0, 1, 3'd7, 0);
        applyStimulus(0, 1, 1, 3'd7, 0);
        @(posedge clk);
        #1;
        checkOutput("block_ignored_id", sfx_id, 1);
        repeat (60) applyStimulus(0, 0, 1, 3'd7, 0);

        // Hit restarts a block with a full duration.
        applyStimulus(0, 1, 1, 3'd7, 0);
        @(posedge clk);
        #1;
        checkOutput("block_start_id", sfx_id, 2);
        repeat (4) applyStimulus(0, 0, 1, 3'd7, 0);
        applyStimulus(1, 0, 1, 3'd7, 0);
        @(posedge clk);
        #1;
        checkOutput("restart_id", sfx_id, 1);
        applyStimulus(0, 0, 1, 3'd7, 0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 39) checkOutput("restart_full_len", sfx_id, 1);
            if (k == 40) checkOutput("restart_end", sfx_id, 0);
        end
        repeat (20) applyStimulus(0, 0, 1, 3'd7, 0);

        // Mute during PLAY, then release.
        applyStimulus(1, 0, 1, 3'd7, 0);
        repeat (5) applyStimulus(0, 0, 1, 3'd7, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 3'd7, 1);
            @(posedge clk);
            #1;
            checkOutput("mute_speaker", speaker, 0);
            checkOutput("mute_busy", sfx_busy, 1);
        end
        repeat (60) applyStimulus(0, 0, 1, 3'd7, 0);

        // Reset in the middle of a PLAY aborts the SFX immediately.
        applyStimulus(1, 0, 1, 3'd7, 0);
        repeat (2) applyStimulus(0, 0, 1, 3'd7, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_speaker", speaker, 0);
        checkOutput("reset_mid_busy", sfx_busy, 0);
        checkOutput("reset_mid_id", sfx_id, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) applyStimulus(0, 0, 1, 3'd7, 0);
        @(posedge clk);
        #1;
        checkOutput("post_reset_busy", sfx_busy, 0);

        // Randomized traffic against the reference model.
        rb = 1'b0;
        rvol = 3'd7;
        rmute = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0)  rb = ~rb;
            if ($urandom_range(0, 199) == 0) rvol = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) rmute = ~rmute;
            rh   = ($urandom_range(0, 79) == 0);
            rblk = ($urandom_range(0, 59) == 0);
            applyStimulus(rh, rblk, rb, rvol, rmute);
        end
        repeat (5) applyStimulus(0, 0, 0, 3'd7, 0);
        @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sfx_audio_mixer.md
Name: sfx_audio_mixer

Overview:
- Sits directly downstream of the background-music generator and drives the PMOD speaker pin.
- Takes the 1-bit BGM square wave and duck-mixes two gameplay sound effects over it, "hit" and "block".
- Sound effects are tones generated internally from single-cycle trigger pulses sent by the fight logic.
- BGM level is scaled by a 3-bit PWM volume; a global mute forces silence.

Parameters:
- HIT_HALF_PER, 113636: hit tone half-period in clk cycles (~440 Hz at 100 MHz).
- BLOCK_HALF_PER, 75757: block tone half-period in clk cycles (~660 Hz).
- SFX_LEN, 10000000: SFX tone duration in clk cycles (100 ms).
- GAP_LEN, 1000000: silent gap after an SFX before BGM resumes (10 ms).
- CNT_W, 24: width of the tone and duration counters; must hold max(SFX_LEN, GAP_LEN, half-periods).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- bgm_in  in  1  BGM square wave from the music generator; may toggle at any time.
- hit_trig  in  1  single-cycle pulse, synchronous to clk: request hit SFX.
- block_trig  in  1  single-cycle pulse, synchronous to clk: request block SFX.
- volume  in  3  BGM PWM level: 0 = off, 7 = full.
- mute  in  1  level-sensitive; forces speaker low.
- speaker  out  1  registered speaker drive.
- sfx_busy  out  1  high in PLAY or GAP.
- sfx_id  out  2  00 none, 01 hit, 10 block; valid while in PLAY.

Behaviour:
- Reset: one clock; asynchronous, active-high `reset`.
  - Asserting `reset` clears all state immediately: FSM=IDLE, all counters=0, synchroniser flops=0.
  - Outputs under reset: speaker=0, sfx_busy=0, sfx_id=00.
  - Reset mid-SFX aborts it; no tone completes after reset is released.
- bgm_in path:
  - Passes through a 2-flop synchroniser before use.
  - Latency bgm_in→speaker is 3 clk cycles: 2 sync flops + output register.
- PWM counter:
  - `pwm_cnt[2:0]` free-runs, incrementing every cycle and wrapping 7→0.
  - `bgm_gate = (volume==7) || (pwm_cnt < volume)`.
  - volume=0 gives constant 0; volume=7 gives a 100% pass-through.
- FSM states are IDLE, PLAY, GAP.
  - IDLE: speaker_next = bgm_sync & bgm_gate. A trigger moves to PLAY; load the duration counter with SFX_LEN-1, reset the tone counter to 0 and tone phase to 1, latch sfx_id.
  - PLAY: speaker_next = tone phase. The tone counter counts up; at half_per-1 it clears and toggles the phase. The duration counter decrements; at 0, go to GAP with the duration counter loaded with GAP_LEN-1 and sfx_id cleared to 00.
  - GAP: speaker_next = 0. The duration counter decrements; at 0, go to IDLE.
- Trigger priority:
  - Simultaneous hit_trig and block_trig: hit wins.
  - A trigger in PLAY or GAP restarts PLAY from scratch only if its priority is ≥ the current sfx_id. Hit ≥ block, and anything beats "none" in GAP.
  - A block_trig during a hit PLAY is ignored (dropped, not queued).
- mute overrides every state: speaker_next = 0.
  - The FSM and counters keep running while muted, so unmuting resumes mid-sequence.
- sfx_busy and sfx_id are registered; they update on the same edge as the state change.
- All counters use CNT_W bits and must never wrap during normal operation.

Optional Feature:
- Macro: SFX_SWEEP_EN.
- Defined: during a hit PLAY, the active half-period increases by 1 each time the phase toggles, giving a falling-pitch "thud".
  - The active half-period is reloaded to HIT_HALF_PER on every hit start or restart.
  - The block tone is unaffected.
- Undefined: both tones use a fixed half-period; the sweep register and its logic are absent.

Test Plan:
- Reset release, volume=7, mute=0, bgm_in toggled every 50 cycles → speaker equals bgm_in delayed by 3 cycles; sfx_busy=0, sfx_id=00.
- Params HIT_HALF_PER=4, SFX_LEN=40, GAP_LEN=10; hit_trig pulse → next cycle sfx_id=01 and sfx_busy=1; speaker toggles every 4 cycles for 40 cycles; then 10 cycles of 0; then back to BGM, sfx_busy=0.
- hit_trig and block_trig in the same cycle → sfx_id=01. block_trig 5 cycles into that hit → no change. hit_trig 5 cycles into a block PLAY → restart with sfx_id=01 and a full 40-cycle duration.
- volume=3, bgm_in held 1 → speaker high on exactly 3 of every 8 cycles; volume=0 → speaker constant 0.
- mute=1 during PLAY → speaker 0, sfx_busy stays 1. Release mute → tone resumes at the correct phase. reset pulse mid-PLAY → outputs 0 immediately, FSM in IDLE.
- With SFX_SWEEP_EN defined: hit tone half-periods observed as 4, 5, 6, 7… cycles between successive speaker edges.
